mux_arbiter: RTL and testbench



---
 rtl/mux_arbiter.sv | 129 ++++++++++++
 tb/tb_mux_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/mux_arbiter.sv
// Two-requester round-robin arbiter and sequencer for a shared 2:1 mux.
// Decides each cycle which source (A or B) owns the mux, drives the
// registered mux select, and presents the owner's data on z_o. It limits
// how long one requester may hold ownership while the other is waiting.
//
// Ports:
//   clk_i    system clock, rising edge
//   rst_i    synchronous reset, active-high
//   req_a_i  requester A wants the mux
//   req_b_i  requester B wants the mux
//   a_i      requester A data (WIDTH)
//   b_i      requester B data (WIDTH)
//   gnt_a_o  A owns the mux (registered)
//   gnt_b_o  B owns the mux (registered)
//   sel_i    mux select, 0 = A, 1 = B (registered; named to match the mux)
//   z_o      owner data when valid_o, else zero (combinational)
//   valid_o  z_o carries live owner data this cycle
module mux_arbiter #(
  parameter int unsigned WIDTH    = 1,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_a_i,
  input  logic             req_b_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             gnt_a_o,
  output logic             gnt_b_o,
  output logic             sel_i,
  output logic [WIDTH-1:0] z_o,
  output logic             valid_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  state_t     state_q, state_d;
  logic       sel_q, sel_d;
  logic       last_q, last_d;   // last-served requester, 0 = A, 1 = B
  logic [3:0] hold_q, hold_d;   // consecutive owned cycles

  logic to_a, to_b, stay;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    hold_d  = hold_q;
    to_a    = 1'b0;
    to_b    = 1'b0;
    stay    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_a_i && req_b_i) begin
          to_a = last_q;
          to_b = !last_q;
        end else begin
          to_a = req_a_i;
          to_b = req_b_i;
        end
      end
      OWN_A: begin
        if (!req_a_i) begin
          if (req_b_i) to_b = 1'b1;
          else         state_d = IDLE;
        end else if (req_b_i && (hold_q >= HOLD_LAST)) begin
          to_b = 1'b1;
        end else begin
          stay = 1'b1;
        end
      end
      OWN_B: begin
        if (!req_b_i) begin
          if (req_a_i) to_a = 1'b1;
          else         state_d = IDLE;
        end else if (req_a_i && (hold_q >= HOLD_LAST)) begin
          to_a = 1'b1;
        end else begin
          stay = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Entering a new ownership restarts the hold count and records the owner;
    // staying counts up and saturates so a lone requester never wraps.
    if (to_a) begin
      state_d = OWN_A;
      sel_d   = 1'b0;
      last_d  = 1'b0;
      hold_d  = '0;
    end else if (to_b) begin
      state_d = OWN_B;
      sel_d   = 1'b1;
      last_d  = 1'b1;
      hold_d  = '0;
    end else if (stay && (hold_q < HOLD_LAST)) begin
      hold_d = hold_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      last_q  <= 1'b1;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

  assign gnt_a_o = (state_q == OWN_A);
  assign gnt_b_o = (state_q == OWN_B);
  assign sel_i   = sel_q;
  assign valid_o = (gnt_a_o && req_a_i) || (gnt_b_o && req_b_i);
  assign z_o     = valid_o ? (sel_q ? b_i : a_i) : '0;

endmodule

// File: tb/tb_mux_arbiter.sv
// Bench for mux_arbiter: table-driven vectors plus hand-written sequences,
// with expected outputs queued at drive time and compared after the edge.
module tb_mux_arbiter;

  logic       clk;
  logic       rst, req_a, req_b;
  logic [3:0] a, b;
  logic       ga, gb, sel, valid;
  logic [3:0] z;
  logic       ga1, gb1, sel1, valid1;
  logic [3:0] z1;

  mux_arbiter #(.WIDTH(4), .MAX_HOLD(4)) dut (
    .clk_i(clk), .rst_i(rst), .req_a_i(req_a), .req_b_i(req_b),
    .a_i(a), .b_i(b), .gnt_a_o(ga), .gnt_b_o(gb), .sel_i(sel),
    .z_o(z), .valid_o(valid)
  );

  mux_arbiter #(.WIDTH(4), .MAX_HOLD(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .req_a_i(req_a), .req_b_i(req_b),
    .a_i(a), .b_i(b), .gnt_a_o(ga1), .gnt_b_o(gb1), .sel_i(sel1),
    .z_o(z1), .valid_o(valid1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         rst, ra, rb;
    logic [3:0] a, b;
    bit         ga, gb, sel, valid;
    logic [3:0] z;
  } vec_t;

  typedef struct {
    bit         which;  // 0 = MAX_HOLD 4 instance, 1 = MAX_HOLD 1 instance
    string      name;
    bit         ga, gb, sel, valid;
    logic [3:0] z;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit ra, input bit rb,
                      input logic [3:0] da, input logic [3:0] db, input exp_t e);
    exp_t g;
    rst = r; req_a = ra; req_b = rb; a = da; b = db;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++; failures++;
      $display("FAIL scoreboard_empty at %s", e.name);
    end else begin
      g = sb.pop_front();
      if (g.which == 1'b0) begin
        chk({g.name, ".gnt_a"}, {3'b0, ga},    {3'b0, g.ga});
        chk({g.name, ".gnt_b"}, {3'b0, gb},    {3'b0, g.gb});
        chk({g.name, ".sel"},   {3'b0, sel},   {3'b0, g.sel});
        chk({g.name, ".valid"}, {3'b0, valid}, {3'b0, g.valid});
        chk({g.name, ".z"},     z,             g.z);
      end else begin
        chk({g.name, ".gnt_a"}, {3'b0, ga1},    {3'b0, g.ga});
        chk({g.name, ".gnt_b"}, {3'b0, gb1},    {3'b0, g.gb});
        chk({g.name, ".sel"},   {3'b0, sel1},   {3'b0, g.sel});
        chk({g.name, ".valid"}, {3'b0, valid1}, {3'b0, g.valid});
        chk({g.name, ".z"},     z1,             g.z);
      end
    end
  endtask

  function automatic exp_t mk(input bit w, input string n, input bit ea, input bit eb,
                              input bit es, input bit ev, input logic [3:0] ez);
    exp_t e;
    e.which = w; e.name = n; e.ga = ea; e.gb = eb; e.sel = es; e.valid = ev; e.z = ez;
    return e;
  endfunction

  vec_t vecs[20];

  initial begin
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0; a = '0; b = '0;

    //           rst ra rb  a      b      ga gb sel v  z
    vecs[0]  = '{1, 0, 0, 4'h3, 4'hC, 0, 0, 0, 0, 4'h0}; // reset state
    vecs[1]  = '{0, 1, 1, 4'h3, 4'hC, 1, 0, 0, 1, 4'h3}; // first tie goes to A
    vecs[2]  = '{0, 1, 1, 4'h7, 4'h2, 1, 0, 0, 1, 4'h7};
    vecs[3]  = '{0, 1, 1, 4'h1, 4'hE, 1, 0, 0, 1, 4'h1};
    vecs[4]  = '{0, 1, 1, 4'hF, 4'h0, 1, 0, 0, 1, 4'hF}; // 4th A cycle
    vecs[5]  = '{0, 1, 1, 4'h2, 4'h9, 0, 1, 1, 1, 4'h9}; // forced handover
    vecs[6]  = '{0, 1, 1, 4'h4, 4'h6, 0, 1, 1, 1, 4'h6};
    vecs[7]  = '{0, 1, 1, 4'h8, 4'hB, 0, 1, 1, 1, 4'hB};
    vecs[8]  = '{0, 1, 1, 4'h5, 4'hD, 0, 1, 1, 1, 4'hD};
    vecs[9]  = '{0, 1, 1, 4'h6, 4'h1, 1, 0, 0, 1, 4'h6}; // back to A
    vecs[10] = '{0, 0, 1, 4'h9, 4'hA, 0, 1, 1, 1, 4'hA}; // direct handover
    vecs[11] = '{0, 0, 0, 4'h7, 4'h7, 0, 0, 1, 0, 4'h0}; // idle, sel held
    vecs[12] = '{0, 0, 0, 4'hF, 4'hF, 0, 0, 1, 0, 4'h0};
    vecs[13] = '{0, 1, 1, 4'h2, 4'h4, 1, 0, 0, 1, 4'h2}; // tie after B -> A
    vecs[14] = '{0, 1, 0, 4'hC, 4'h3, 1, 0, 0, 1, 4'hC};
    vecs[15] = '{0, 0, 1, 4'hC, 4'h3, 0, 1, 1, 1, 4'h3}; // release + request
    vecs[16] = '{0, 0, 0, 4'h1, 4'h2, 0, 0, 1, 0, 4'h0};
    vecs[17] = '{0, 0, 1, 4'h1, 4'h2, 0, 1, 1, 1, 4'h2};
    vecs[18] = '{1, 0, 1, 4'h1, 4'h2, 0, 0, 0, 0, 4'h0}; // reset mid-OWN_B
    vecs[19] = '{0, 0, 1, 4'h1, 4'h6, 0, 1, 1, 1, 4'h6}; // grant returns

    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 20; i++) begin
      step(vecs[i].rst, vecs[i].ra, vecs[i].rb, vecs[i].a, vecs[i].b,
           mk(1'b0, $sformatf("vec%0d", i), vecs[i].ga, vecs[i].gb,
              vecs[i].sel, vecs[i].valid, vecs[i].z));
    end

    // Lone requester B for 20 cycles: no handover, hold count saturates at 3.
    step(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, mk(1'b0, "lone_rst", 0, 0, 0, 0, 4'h0));
    for (int i = 0; i < 20; i++) begin
      logic [3:0] bv;
      bv = 4'(i + 1);
      step(1'b0, 1'b0, 1'b1, 4'hF, bv,
           mk(1'b0, $sformatf("lone_b%0d", i), 0, 1, 1, 1, bv));
      chk($sformatf("lone_b%0d.hold", i), dut.hold_q, (i < 3) ? 4'(i) : 4'd3);
    end
    // A arrives while B's count is saturated: handover on the very next edge.
    step(1'b0, 1'b1, 1'b1, 4'h5, 4'hA, mk(1'b0, "sat_handover", 1, 0, 0, 1, 4'h5));
    // Owner drops its request between edges: valid and z fall immediately,
    // the registered grant stays until the next edge.
    req_a = 1'b0;
    #1;
    chk("drop_mid.valid", {3'b0, valid}, 4'h0);
    chk("drop_mid.z",     z,             4'h0);
    chk("drop_mid.gnt_a", {3'b0, ga},    4'h1);
    step(1'b0, 1'b0, 1'b1, 4'h5, 4'hA, mk(1'b0, "drop_handover", 0, 1, 1, 1, 4'hA));

    // MAX_HOLD = 1: strict alternation while both request.
    step(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, mk(1'b1, "alt_rst", 0, 0, 0, 0, 4'h0));
    for (int i = 0; i < 6; i++) begin
      bit ea;
      ea = (i % 2 == 0);
      step(1'b0, 1'b1, 1'b1, 4'h3, 4'hC,
           mk(1'b1, $sformatf("alt%0d", i), ea, !ea, !ea, 1, ea ? 4'h3 : 4'hC));
    end

    if (sb.size() != 0) begin
      checks++; failures++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1);
  end

endmodule
